// File: rtl/sseg_pkg.sv
// Shared glyphs, anode constants and scan FSM state for the seven-segment scan controller.
// All segment encodings are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] bcd;
    } disp_t;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment glyph; codes 10-15 show a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_scan_controller.sv
// Four-digit common-anode scan controller: blank-guarded digit slots, frame-atomic value
// commit, leading-zero suppression. Outputs are registered from the next-state values.
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV     = 49999,
    parameter int BLANK_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    disp_t         pend, act;

    logic          slot_end, commit;
    logic [3:0]    digit;
    logic [6:0]    glyph;
    logic [3:0]    zero, sup;
    logic          suppress;

    assign slot_end = (cnt == CW'(SCAN_DIV));
    assign commit   = slot_end && (idx == 2'd3);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        case (state)
            BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) state_nx = DRIVE;
            DRIVE: if (slot_end) begin
                state_nx = BLANK;
                cnt_nx   = '0;
                idx_nx   = idx + 2'd1;
            end
            default: state_nx = BLANK;
        endcase
    end

    // A digit is suppressed only when it and every more-significant digit are zero.
    always_comb begin
        for (int k = 0; k < 4; k++) zero[k] = (act.bcd[4*k +: 4] == 4'd0);
        sup[3] = zero[3];
        sup[2] = sup[3] & zero[2];
        sup[1] = sup[2] & zero[1];
        sup[0] = 1'b0;
    end

    assign digit    = act.bcd[4*idx_nx +: 4];
    assign suppress = blank_lz && sup[idx_nx];

    bcd_to_sseg u_dec (
        .bcd (digit),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            pend       <= '0;
            act        <= '0;
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            if (load) pend <= '{dp: dp_in, bcd: bcd_in};
            // A load coinciding with the commit goes straight to the display.
            if (commit) act <= load ? '{dp: dp_in, bcd: bcd_in} : pend;
            frame_done <= (cnt_nx == CW'(SCAN_DIV)) && (idx_nx == 2'd3);
            if (state_nx == DRIVE) begin
                an   <= ~(4'b0001 << idx_nx);
                sseg <= suppress ? SEG_OFF : glyph;
                dp   <= ~act.dp[idx_nx];
            end else begin
                an   <= AN_OFF;
                sseg <= SEG_OFF;
                dp   <= 1'b1;
            end
        end
    end

endmodule
